// File: rtl/fm_nco.sv
// FM carrier NCO: carrier word plus scaled audio sample integrated into a phase accumulator.
// Optional FM_NCO_DITHER_EN adds LFSR dither to the phase used for the 1-bit RF output.
module fm_nco #(
  parameter int unsigned PHASE_W      = 32,
  parameter int unsigned SAMPLE_W     = 16,
  parameter int unsigned DEV_SHIFT    = 8,
  parameter int unsigned UNDERRUN_CYC = 4096
) (
  input  logic                clk,
  input  logic                areset,
  input  logic                enable,
  input  logic [PHASE_W-1:0]  carrier_word,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                rf_out,
  output logic [PHASE_W-1:0]  phase_out,
  output logic                underrun
);

  localparam int unsigned CNT_W = $clog2(UNDERRUN_CYC + 1);
  localparam int unsigned EXT_W = PHASE_W - SAMPLE_W;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nxt;
  logic [PHASE_W-1:0]  carrier_reg;
  logic [SAMPLE_W-1:0] sample_reg;
  logic [PHASE_W-1:0]  freq_word;
  logic [PHASE_W-1:0]  phase_acc;
  logic [CNT_W-1:0]    starve_cnt;
  logic                accept;
  logic [PHASE_W-1:0]  offset;
  logic [PHASE_W-1:0]  freq_sum;
  logic [PHASE_W-1:0]  phase_nxt;
  logic [CNT_W-1:0]    cnt_inc;
  logic                rf_bit;

  // State register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and ready handshake
  always_comb begin
    state_nxt    = state;
    sample_ready = 1'b0;
    case (state)
      IDLE: if (enable)  state_nxt = RUN;
      RUN: begin
        sample_ready = ~areset;
        if (!enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = sample_valid & sample_ready;
  assign offset    = {{EXT_W{sample_reg[SAMPLE_W-1]}}, sample_reg} << DEV_SHIFT;
  assign freq_sum  = carrier_reg + offset;
  assign phase_nxt = phase_acc + freq_word;
  assign cnt_inc   = starve_cnt + CNT_W'(1);
  assign phase_out = phase_acc;

`ifdef FM_NCO_DITHER_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  logic [15:0]        lfsr;
  logic [PHASE_W-1:0] dither_sum;

  // Galois LFSR, parked at the seed while idle
  always_ff @(posedge clk or posedge areset) begin
    if (areset)             lfsr <= LFSR_SEED;
    else if (state == IDLE) lfsr <= LFSR_SEED;
    else                    lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  assign dither_sum = phase_nxt + PHASE_W'(lfsr);
  assign rf_bit     = dither_sum[PHASE_W-1];
`else
  assign rf_bit = phase_nxt[PHASE_W-1];
`endif

  // Datapath: sample capture, frequency word, accumulator and starvation watchdog
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      carrier_reg <= '0;
      sample_reg  <= '0;
      freq_word   <= '0;
      phase_acc   <= '0;
      starve_cnt  <= '0;
      underrun    <= 1'b0;
      rf_out      <= 1'b0;
    end else begin
      freq_word <= freq_sum;
      if (state == IDLE) begin
        carrier_reg <= carrier_word;
        sample_reg  <= '0;
        phase_acc   <= '0;
        starve_cnt  <= '0;
        underrun    <= 1'b0;
        rf_out      <= 1'b0;
      end else begin
        phase_acc <= phase_nxt;
        rf_out    <= rf_bit;
        if (accept) begin
          sample_reg <= sample_data;
          starve_cnt <= '0;
          underrun   <= 1'b0;
        end else if (starve_cnt != CNT_W'(UNDERRUN_CYC)) begin
          starve_cnt <= cnt_inc;
          // Starved long enough: drop modulation back to the bare carrier
          if (cnt_inc == CNT_W'(UNDERRUN_CYC)) begin
            sample_reg <= '0;
            underrun   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fm_nco.sv
// Directed bench for fm_nco: carrier stepping, sample modulation latency,
// carrier freeze, starvation underrun and asynchronous reset.
module tb_fm_nco;

  logic        clk;
  logic        areset;
  logic        enable;
  logic [31:0] carrier_word;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        rf_out;
  logic [31:0] phase_out;
  logic        underrun;

  int checks;
  int failures;

  fm_nco #(
    .PHASE_W(32), .SAMPLE_W(16), .DEV_SHIFT(8), .UNDERRUN_CYC(16)
  ) dut (
    .clk(clk), .areset(areset), .enable(enable), .carrier_word(carrier_word),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .rf_out(rf_out), .phase_out(phase_out), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ph1 [4];
  logic        rf1 [4];
  logic [31:0] ph2 [8];
  logic [31:0] exp_ph;
  logic [31:0] inc;

  initial begin
    checks = 0;
    failures = 0;
    ph1 = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0000_0000};
    rf1 = '{1'b0, 1'b1, 1'b1, 1'b0};
    // accept 0x0100 at edge 0, 0xFF00 at edge 4
    ph2 = '{32'h4000_0000, 32'h8000_0000, 32'hC001_0000, 32'h0002_0000,
            32'h4003_0000, 32'h8004_0000, 32'hC003_0000, 32'h0002_0000};

    areset = 1'b1; enable = 1'b0; carrier_word = 32'h4000_0000;
    sample_data = '0; sample_valid = 1'b0;
    repeat (2) step();
    check("rst_phase", phase_out, 32'h0);
    check("rst_rf", 32'(rf_out), 32'h0);
    check("rst_ready", 32'(sample_ready), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);

    // Carrier only
    areset = 1'b0;
    step(); step();
    enable = 1'b1;
    check("idle_ready", 32'(sample_ready), 32'h0);
    step();
    check("run_ready", 32'(sample_ready), 32'h1);
    check("run_first_phase", phase_out, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("s1_phase%0d", i), phase_out, ph1[i]);
      check($sformatf("s1_rf%0d", i), 32'(rf_out), 32'(rf1[i]));
      check($sformatf("s1_underrun%0d", i), 32'(underrun), 32'h0);
    end

    // Modulation latency and negative sample
    for (int i = 0; i < 8; i++) begin
      sample_valid = (i == 0 || i == 4);
      sample_data  = (i == 4) ? 16'hFF00 : 16'h0100;
      step();
      check($sformatf("s2_phase%0d", i), phase_out, ph2[i]);
    end
    sample_valid = 1'b0;

    // Carrier frozen during RUN, reloaded in IDLE
    carrier_word = 32'h1234_5678;
    step();
    check("s3_frozen0", phase_out, 32'h4001_0000);
    step();
    check("s3_frozen1", phase_out, 32'h8000_0000);
    enable = 1'b0;
    carrier_word = 32'h2000_0000;
    step();
    check("s3_last_run", phase_out, 32'hBFFF_0000);
    step();
    check("s3_idle_phase", phase_out, 32'h0);
    check("s3_idle_ready", 32'(sample_ready), 32'h0);
    step();
    enable = 1'b1;
    step();
    check("s3_restart", phase_out, 32'h0);
    step();
    check("s3_step0", phase_out, 32'h2000_0000);
    step();
    check("s3_step1", phase_out, 32'h4000_0000);

    // Starvation: one sample then 16 idle cycles
    exp_ph = 32'h4000_0000 + 32'h2000_0000;
    sample_valid = 1'b1;
    sample_data  = 16'h7FFF;
    step();
    sample_valid = 1'b0;
    check("s4_accept_phase", phase_out, exp_ph);
    for (int k = 1; k <= 18; k++) begin
      inc = (k >= 2 && k <= 17) ? 32'h207F_FF00 : 32'h2000_0000;
      exp_ph = exp_ph + inc;
      step();
      check($sformatf("s4_phase%0d", k), phase_out, exp_ph);
      if (k == 15) check("s4_underrun_pre", 32'(underrun), 32'h0);
      if (k == 16) check("s4_underrun_set", 32'(underrun), 32'h1);
      if (k == 18) check("s4_underrun_sticky", 32'(underrun), 32'h1);
    end
    sample_valid = 1'b1;
    sample_data  = 16'h0000;
    step();
    sample_valid = 1'b0;
    check("s4_underrun_clear", 32'(underrun), 32'h0);

    // Asynchronous reset mid-RUN
    step();
    areset = 1'b1;
    #1;
    check("s5_rst_phase", phase_out, 32'h0);
    check("s5_rst_rf", 32'(rf_out), 32'h0);
    check("s5_rst_ready", 32'(sample_ready), 32'h0);
    check("s5_rst_underrun", 32'(underrun), 32'h0);
    step();
    areset = 1'b0;
    step();
    check("s5_idle_edge", phase_out, 32'h0);
    step();
    check("s5_first_run", phase_out, 32'h0);
    step();
    check("s5_step0", phase_out, 32'h2000_0000);
    step();
    check("s5_step1", phase_out, 32'h4000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
